// File: rtl/flash_xip_reader.sv
// rtl/flash_xip_reader.sv - SPI NOR execute-in-place word reader (READ 0x03, SPI mode 0)
// Holds flash selected between sequential word fetches so consecutive reads skip the command phase.
module flash_xip_reader #(
  parameter int CLK_DIV         = 1,
  parameter int CSB_HIGH_CYCLES = 4,
  parameter int WAKE_CYCLES     = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [23:0] addr,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0_oe,
  output logic        flash_io0_do,
  input  logic        flash_io1_di
);
  localparam int WAIT_CYC = (WAKE_CYCLES > CSB_HIGH_CYCLES) ? WAKE_CYCLES : CSB_HIGH_CYCLES;
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] WAIT_LAST = 16'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
  localparam logic [15:0] GAP_LAST  = 16'((CSB_HIGH_CYCLES > 0) ? CSB_HIGH_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_WAKE_CMD, S_WAKE_WAIT, S_IDLE, S_CMD, S_DATA, S_HOLD, S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic        csb_q, csb_d, sclk_q, sclk_d, oe_q, oe_d, do_q, do_d;
  logic        ready_q, ready_d, seq_vld_q, seq_vld_d;
  logic [31:0] rdata_q, rdata_d, sh_q, sh_d, rx_q, rx_d;
  logic [23:0] cur_addr_q, cur_addr_d, next_addr_q, next_addr_d;
  logic [5:0]  bit_q, bit_d;
  logic [15:0] div_q, div_d, wait_q, wait_d;
  logic        shifting, half_end, bit_end, addr_unused;
  logic [31:0] rx_next;

  assign addr_unused = ^addr[1:0];
  assign shifting = (state_q == S_CMD) || (state_q == S_DATA) ||
                    ((state_q == S_WAKE_CMD) && !csb_q);
  assign half_end = (div_q == DIV_LAST);
  // A bit ends on the edge that closes the flash_clk high phase; io1 is sampled there.
  assign bit_end  = shifting && sclk_q && half_end;
  assign rx_next  = {rx_q[30:0], flash_io1_di};

  always_comb begin
    state_d     = state_q;
    csb_d       = csb_q;
    sclk_d      = sclk_q;
    oe_d        = oe_q;
    do_d        = do_q;
    ready_d     = 1'b0;
    seq_vld_d   = seq_vld_q;
    rdata_d     = rdata_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    cur_addr_d  = cur_addr_q;
    next_addr_d = next_addr_q;
    bit_d       = bit_q;
    div_d       = div_q;
    wait_d      = wait_q;

    if (shifting) begin
      if (half_end) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        div_d = div_q + 16'd1;
      end
    end

    case (state_q)
      S_WAKE_CMD: begin
        if (csb_q) begin
          csb_d  = 1'b0;
          oe_d   = 1'b1;
          sh_d   = 32'hAB00_0000;
          do_d   = 1'b1;
          bit_d  = '0;
          div_d  = '0;
          sclk_d = 1'b0;
        end else if (bit_end) begin
          if (bit_q == 6'd7) begin
            csb_d   = 1'b1;
            oe_d    = 1'b0;
            do_d    = 1'b0;
            wait_d  = '0;
            state_d = S_WAKE_WAIT;
          end else begin
            sh_d  = {sh_q[30:0], 1'b0};
            do_d  = sh_q[30];
            bit_d = bit_q + 6'd1;
          end
        end
      end
      S_WAKE_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_IDLE;
        else                     wait_d  = wait_q + 16'd1;
      end
      S_IDLE: begin
        if (valid) begin
          cur_addr_d = {addr[23:2], 2'b00};
          sh_d       = {8'h03, addr[23:2], 2'b00};
          do_d       = 1'b0;
          csb_d      = 1'b0;
          oe_d       = 1'b1;
          bit_d      = '0;
          div_d      = '0;
          sclk_d     = 1'b0;
          state_d    = S_CMD;
        end
      end
      S_CMD: begin
        if (bit_end) begin
          if (bit_q == 6'd31) begin
            oe_d    = 1'b0;
            do_d    = 1'b0;
            bit_d   = '0;
            state_d = S_DATA;
          end else begin
            sh_d  = {sh_q[30:0], 1'b0};
            do_d  = sh_q[30];
            bit_d = bit_q + 6'd1;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          rx_d = rx_next;
          if (bit_q == 6'd31) begin
            ready_d     = 1'b1;
            rdata_d     = {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};
            next_addr_d = cur_addr_q + 24'd4;
            seq_vld_d   = 1'b1;
            bit_d       = '0;
            state_d     = S_HOLD;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end
      end
      S_HOLD: begin
        // The request still on the bus during the ready cycle is the one just served.
        if (valid && !ready_q) begin
          if (seq_vld_q && (addr[23:2] == next_addr_q[23:2])) begin
            cur_addr_d = next_addr_q;
            bit_d      = '0;
            div_d      = '0;
            sclk_d     = 1'b0;
            state_d    = S_DATA;
          end else begin
            csb_d   = 1'b1;
            wait_d  = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (wait_q == GAP_LAST) state_d = S_IDLE;
        else                    wait_d  = wait_q + 16'd1;
      end
      default: state_d = S_WAKE_CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_WAKE_CMD;
      csb_q       <= 1'b1;
      sclk_q      <= 1'b0;
      oe_q        <= 1'b0;
      do_q        <= 1'b0;
      ready_q     <= 1'b0;
      seq_vld_q   <= 1'b0;
      rdata_q     <= '0;
      sh_q        <= '0;
      rx_q        <= '0;
      cur_addr_q  <= '0;
      next_addr_q <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      csb_q       <= csb_d;
      sclk_q      <= sclk_d;
      oe_q        <= oe_d;
      do_q        <= do_d;
      ready_q     <= ready_d;
      seq_vld_q   <= seq_vld_d;
      rdata_q     <= rdata_d;
      sh_q        <= sh_d;
      rx_q        <= rx_d;
      cur_addr_q  <= cur_addr_d;
      next_addr_q <= next_addr_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      wait_q      <= wait_d;
    end
  end

  assign ready        = ready_q;
  assign rdata        = rdata_q;
  assign flash_csb    = csb_q;
  assign flash_clk    = sclk_q;
  assign flash_io0_oe = oe_q;
  assign flash_io0_do = do_q;
endmodule

// File: tb/tb_flash_xip_reader.sv
// tb/tb_flash_xip_reader.sv - scoreboard bench for flash_xip_reader
// Two DUTs (CLK_DIV=1 and 2) share one behavioural SPI NOR model through a pin mux.
module tb_flash_xip_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst2, valid;
  logic [23:0] addr;
  logic        ready1, ready2, csb1, csb2, sclk1, sclk2, oe1, oe2, do1, do2;
  logic [31:0] rdata1, rdata2;
  logic        f_io1 = 1'b0;
  logic        sel = 1'b0;

  flash_xip_reader #(.CLK_DIV(1), .CSB_HIGH_CYCLES(4), .WAKE_CYCLES(48)) u_dut1 (
    .clk(clk), .rst(rst1), .valid(valid && !sel), .addr(addr), .ready(ready1), .rdata(rdata1),
    .flash_csb(csb1), .flash_clk(sclk1), .flash_io0_oe(oe1), .flash_io0_do(do1),
    .flash_io1_di(f_io1));

  flash_xip_reader #(.CLK_DIV(2), .CSB_HIGH_CYCLES(4), .WAKE_CYCLES(48)) u_dut2 (
    .clk(clk), .rst(rst2), .valid(valid && sel), .addr(addr), .ready(ready2), .rdata(rdata2),
    .flash_csb(csb2), .flash_clk(sclk2), .flash_io0_oe(oe2), .flash_io0_do(do2),
    .flash_io1_di(f_io1));

  logic        f_csb, f_clk, f_oe, f_io0, m_ready;
  logic [31:0] m_rdata;
  assign f_csb   = sel ? csb2   : csb1;
  assign f_clk   = sel ? sclk2  : sclk1;
  assign f_oe    = sel ? oe2    : oe1;
  assign f_io0   = sel ? do2    : do1;
  assign m_ready = sel ? ready2 : ready1;
  assign m_rdata = sel ? rdata2 : rdata1;

  int tests = 0;
  int fails = 0;
  int pos_cnt = 0;
  always @(posedge clk) pos_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    tests++;
    if (act < min) begin
      fails++;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] ^ 8'h03 ^ a[15:8] ^ a[23:16];
  endfunction

  // Behavioural SPI NOR: captures io0 on rising flash_clk, drives io1 after falling flash_clk.
  int          ab_cnt = 0;
  int          cmd_cnt = 0;
  int          fl_cnt = 0;
  int          fl_bit = 7;
  logic        fl_data = 1'b0;
  logic [31:0] fl_sh = '0;
  logic [31:0] last_cmd = '0;
  logic [23:0] fl_ptr = '0;
  logic [7:0]  fl_byte;

  always @(negedge f_csb) begin
    fl_cnt  = 0;
    fl_data = 1'b0;
  end

  always @(posedge f_clk) begin
    if (!f_csb && !fl_data) begin
      if (!f_oe) begin
        tests++;
        fails++;
        $display("FAIL io0_oe: got 0 during command bit %0d, expected 1", fl_cnt);
      end
      fl_sh = {fl_sh[30:0], f_io0};
      fl_cnt++;
      if (fl_cnt == 8 && fl_sh[7:0] == 8'hAB) ab_cnt++;
      if (fl_cnt == 32 && fl_sh[31:24] == 8'h03) begin
        cmd_cnt++;
        last_cmd = fl_sh;
        fl_ptr   = fl_sh[23:0];
        fl_bit   = 7;
        fl_data  = 1'b1;
      end
    end
  end

  always @(negedge f_clk) begin
    if (!f_csb && fl_data) begin
      #1;
      fl_byte = flash_byte(fl_ptr);
      f_io1   = fl_byte[fl_bit];
      if (fl_bit == 0) begin
        fl_bit = 7;
        fl_ptr = fl_ptr + 24'd1;
      end else begin
        fl_bit--;
      end
    end
  end

  int csb_run = 0;
  int last_run = 0;
  int rise_cnt = 0;
  always @(posedge f_csb) rise_cnt++;
  always @(negedge clk) begin
    if (f_csb) csb_run++;
    else if (csb_run > 0) begin
      last_run = csb_run;
      csb_run  = 0;
    end
  end

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          issued;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (m_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_ready: got ready=1 at cycle %0d, expected no ready", pos_cnt);
      end else begin
        mon_e = sb.pop_front();
        check("rdata", m_rdata, mon_e.data);
        check("ready_latency", 32'(pos_cnt - mon_e.issued), 32'(mon_e.lat));
      end
    end
  end

  task automatic do_read(input logic [23:0] a, input logic [31:0] exp_data, input int exp_lat);
    int k;
    sb.push_back('{exp_data, exp_lat, pos_cnt});
    valid = 1'b1;
    addr  = a;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_ready && k < 3000);
    if (!m_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got no ready for addr 0x%06h, expected one", a);
      sb.delete();
    end
    valid = 1'b0;
    @(negedge clk);
  endtask

  int rise0;

  initial begin
    rst1  = 1'b1;
    rst2  = 1'b1;
    valid = 1'b0;
    addr  = '0;
    repeat (3) @(negedge clk);
    check("reset_csb", 32'(csb1), 32'd1);
    check("reset_clk", 32'(sclk1), 32'd0);
    check("reset_oe", 32'(oe1), 32'd0);
    check("reset_do", 32'(do1), 32'd0);
    check("reset_ready", 32'(ready1), 32'd0);
    check("reset_rdata", rdata1, 32'h0);
    rst1 = 1'b0;
    repeat (120) @(negedge clk);
    check("wake_ab_sent", 32'(ab_cnt), 32'd1);
    check("wake_no_cmd", 32'(cmd_cnt), 32'd0);

    do_read(24'h000010, 32'h10111213, 129);
    check("cmd_count_first", 32'(cmd_cnt), 32'd1);
    check("cmd_word_first", last_cmd, 32'h03000010);
    check_ge("wake_csb_high", last_run, 48);

    rise0 = rise_cnt;
    do_read(24'h000014, 32'h14151617, 65);
    check("seq_no_cmd", 32'(cmd_cnt), 32'd1);
    check("seq_csb_low", 32'(rise_cnt), 32'(rise0));

    do_read(24'h000020, 32'h20212223, 134);
    do_read(24'h000100, 32'h01000302, 134);
    check("nonseq_cmd_count", 32'(cmd_cnt), 32'd3);
    check("nonseq_cmd_word", last_cmd, 32'h03000100);
    check_ge("nonseq_csb_gap", last_run, 4);

    do_read(24'hFFFFFC, 32'hFCFDFEFF, 134);
    do_read(24'h000000, 32'h00010203, 65);
    check("wrap_no_cmd", 32'(cmd_cnt), 32'd4);

    valid = 1'b1;
    addr  = 24'h000040;
    repeat (40) @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1  = 1'b0;
    valid = 1'b0;
    check("midrst_csb", 32'(csb1), 32'd1);
    check("midrst_clk", 32'(sclk1), 32'd0);
    check("midrst_oe", 32'(oe1), 32'd0);
    check("midrst_ready", 32'(ready1), 32'd0);
    repeat (120) @(negedge clk);
    check("midrst_ab_resent", 32'(ab_cnt), 32'd2);
    do_read(24'h000004, 32'h04050607, 129);
    check("midrst_cmd_resent", 32'(cmd_cnt), 32'd5);

    rst1 = 1'b1;
    sel  = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    repeat (200) @(negedge clk);
    check("div2_ab_sent", 32'(ab_cnt), 32'd3);
    do_read(24'h000010, 32'h10111213, 257);
    check("div2_cmd_word", last_cmd, 32'h03000010);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/flash_xip_reader.md
Name: flash_xip_reader

Overview:
- Memory-mapped read port for the external SPI NOR flash, sitting between the SoC memory bus and the flash pins (flash_csb, flash_clk, flash_io0..3) of the hardware top.
- Converts 32-bit word reads on a valid/ready bus into SPI mode-0 READ (0x03) transactions.
- Keeps the flash selected across sequential word fetches so code can execute in place.
- Issues a release-power-down (0xAB) after reset.

Parameters:
CLK_DIV, 1, flash_clk half-period in clk cycles (>=1)
CSB_HIGH_CYCLES, 4, minimum flash_csb high time between transactions, in clk cycles
WAKE_CYCLES, 48, wait after the 0xAB command before the first read, in clk cycles

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
valid  in  1  read request; held high with addr stable until ready
addr  in  24  byte address; addr[1:0] ignored (treated as 0)
ready  out  1  one-cycle pulse: rdata valid, request complete
rdata  out  32  read word, little-endian (first flash byte -> rdata[7:0])
flash_csb  out  1  chip select, active low
flash_clk  out  1  SPI clock, idle low (mode 0)
flash_io0_oe  out  1  io0 output enable (MOSI phase)
flash_io0_do  out  1  io0 output data
flash_io1_di  in  1  io1 input (MISO)

The top drives io2/io3 high (WP#/HOLD# inactive).

Behaviour:
Clock and reset:
- One clock: clk. Reset rst is synchronous and active-high.
- Reset values: flash_csb=1, flash_clk=0, flash_io0_oe=0, flash_io0_do=0, ready=0, rdata=0. State = WAKE_CMD; sequence-tracking register invalid.

Bit timing (all SPI transfers, MSB first):
- Each bit lasts 2*CLK_DIV clk cycles: CLK_DIV cycles with flash_clk low, then CLK_DIV with flash_clk high.
- io0_do changes only while flash_clk is low.
- io1_di is sampled on the clk edge that ends the high phase.

States:
- WAKE_CMD:
  - Assert csb.
  - Shift 8 bits of 0xAB with oe=1.
  - Deassert csb and set oe=0.
  - Go to WAKE_WAIT.
- WAKE_WAIT:
  - Count max(WAKE_CYCLES, CSB_HIGH_CYCLES), then go to IDLE.
  - valid is ignored until IDLE.
- IDLE (csb=1):
  - On valid, latch {addr[23:2],2'b00}.
  - Next cycle: csb=0, go to CMD.
- CMD:
  - Shift 32 bits, {0x03, addr[23:0]}, with oe=1.
  - Then oe=0 and go to DATA.
- DATA:
  - Shift in 32 bits; byte k goes to rdata[8k+7:8k].
  - One cycle after the last sample: ready=1 for one cycle, rdata updated.
  - Record next_addr = addr+4 mod 2^24.
  - Go to HOLD with csb still 0 and flash_clk 0.
- HOLD (csb=0, clk=0):
  - valid with addr[23:2]==next_addr[23:2]: go directly to DATA. No command is sent.
  - valid with any other address: csb=1, go to GAP.
  - No valid: stay in HOLD indefinitely.
- GAP:
  - Keep csb=1 for CSB_HIGH_CYCLES.
  - Then behave as IDLE with the pending request: latch its address and start CMD.

Latency (cycle T = first cycle valid is sampled high):
- From IDLE: csb falls at T+1; ready at T+1+128*CLK_DIV.
- Sequential from HOLD: ready at T+1+64*CLK_DIV.
- Non-sequential from HOLD: ready at T+1+CSB_HIGH_CYCLES+1+128*CLK_DIV.

Boundary conditions:
- Wrap: next_addr 0xFFFFFC+4 = 0x000000 counts as sequential. Flash wrap is relied upon.
- ready is never asserted without a prior valid.
- A new request is not accepted in the ready cycle. Requests are accepted from the following cycle.
- valid dropped before ready is illegal. The controller completes the transaction and pulses ready anyway.
- rst mid-transaction: next cycle csb=1, clk=0, oe=0, ready=0, and the wake sequence restarts. The sequence register is invalidated, so the first read after reset always sends a command.

Test Plan:
- Reset release, CLK_DIV=1 -> 0xAB on io0 across 8 flash_clk pulses, csb high ≥48 cycles, no ready.
- Flash bytes 0x10..0x13 = 13 12 11 10; read addr 0x000010 -> io0 carries 0x03000010; ready exactly 129 cycles after valid; rdata=0x10111213.
- Back-to-back reads 0x000010 then 0x000014 -> second transaction has no command/address bits, csb stays low, ready 65 cycles after the second valid.
- Read 0x000020 then 0x000100 -> csb high for 4 cycles between transactions, full command resent, correct data.
- Read 0xFFFFFC then 0x000000 -> second read treated as sequential (no command), data equals flash bytes 0..3.
- Assert rst for 1 cycle at cycle 40 of a read -> csb=1 and clk=0 next cycle, no ready, 0xAB resent. CLK_DIV=2 rerun of test 2 -> ready at T+257.
